mvm_axis_loader: RTL

Hardware command sequencer that streams MVM programs into the NoC over AXI-Stream: register-file weight loads, input vectors and MVM instructions, fanned out over a contiguous range of router destinations. It sits between the host/DMA word buffer and the `mvm_top` slave port. It generalises weight/vector/instruction injection to any tile count, line count and data width. It honours `TREADY` backpressure and reports completion.

---
 rtl/mvm_loader_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 32 +++
 rtl/mvm_axis_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mvm_loader_pkg.sv
// mvm_loader_pkg: shared op/state enums, latched-command struct and tuser field offsets for the MVM loader
package mvm_loader_pkg;
  typedef enum logic [1:0] {
    OP_INSTR   = 2'b00,
    OP_RSVD    = 2'b01,
    OP_VECTOR  = 2'b10,
    OP_WEIGHTS = 2'b11
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_WEIGHTS, S_VECTOR, S_INSTR, S_FIN} state_e;
  typedef struct packed {
    op_e         op;
    logic [31:0] dest;
    logic [31:0] ndest;
    logic [31:0] nlines;
    logic [31:0] instr;
  } cmd_t;
  function automatic int user_op_lsb(input int rfaw);
    return rfaw;
  endfunction
  function automatic int user_line_lsb(input int rfaw);
    return rfaw + 2;
  endfunction
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream register slice that holds its beat stable while stalled
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = in_ready && in_valid ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/mvm_axis_loader.sv
// mvm_axis_loader: sequences weight, vector and instruction beats onto an AXI-Stream NoC port over a destination range
module mvm_axis_loader
  import mvm_loader_pkg::*;
#(
  parameter int DATAW = 512,
  parameter int DESTW = 12,
  parameter int LINES = 64,
  parameter int RFAW  = 9,
  parameter int IDW   = 8,
  parameter int USERW = LINES + RFAW + 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_OP,
  input  logic [DESTW-1:0]         CMD_DEST,
  input  logic [DESTW-1:0]         CMD_NDEST,
  input  logic [$clog2(LINES):0]   CMD_NLINES,
  input  logic [RFAW-1:0]          CMD_RFADDR,
  input  logic [31:0]              CMD_INSTR,
  input  logic [IDW-1:0]           CMD_ID,
  input  logic                     SRC_TVALID,
  output logic                     SRC_TREADY,
  input  logic [DATAW-1:0]         SRC_TDATA,
  output logic                     AXIS_M_TVALID,
  input  logic                     AXIS_M_TREADY,
  output logic [DATAW-1:0]         AXIS_M_TDATA,
  output logic [USERW-1:0]         AXIS_M_TUSER,
  output logic [DESTW-1:0]         AXIS_M_TDEST,
  output logic [IDW-1:0]           AXIS_M_TID,
  output logic                     AXIS_M_TLAST,
  output logic                     DONE,
  output logic                     ERR
);
  localparam int NLW = $clog2(LINES) + 1;
  localparam int BW  = DATAW + USERW + DESTW + IDW + 1;
  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [RFAW-1:0] rfaddr_q, rfaddr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     d_q, d_d, l_q, l_d;
  logic            done_q, done_d, err_q, err_d;
  logic            src_st, can_acc, gen, bad, last_line, last_dest, out_valid;
  logic [DATAW-1:0] data;
  logic [USERW-1:0] user;
  logic [BW-1:0]    bus, out_bus;
  always_comb begin
    src_st    = state_q == S_WEIGHTS || state_q == S_VECTOR;
    gen       = can_acc && (state_q == S_INSTR || (src_st && SRC_TVALID));
    bad       = CMD_NDEST == '0 || CMD_OP == OP_RSVD ||
                (CMD_OP == OP_WEIGHTS && (CMD_NLINES == '0 || CMD_NLINES > NLW'(LINES)));
    last_line = state_q != S_WEIGHTS || l_q == cmd_q.nlines - 32'd1;
    last_dest = d_q == cmd_q.ndest - 32'd1;
    state_d   = state_q;
    cmd_d     = cmd_q;
    rfaddr_d  = rfaddr_q;
    id_d      = id_q;
    d_d       = d_q;
    l_d       = l_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_IDLE && CMD_VALID) begin
      cmd_d.op     = op_e'(CMD_OP);
      cmd_d.dest   = 32'(CMD_DEST);
      cmd_d.ndest  = 32'(CMD_NDEST);
      cmd_d.nlines = 32'(CMD_NLINES);
      cmd_d.instr  = CMD_INSTR;
      rfaddr_d     = CMD_RFADDR;
      id_d         = CMD_ID;
      d_d          = '0;
      l_d          = '0;
      done_d       = bad;
      err_d        = bad;
      state_d      = bad ? S_FIN :
                     CMD_OP == OP_WEIGHTS ? S_WEIGHTS :
                     CMD_OP == OP_VECTOR ? S_VECTOR : S_INSTR;
    end
    if (gen) begin
      l_d     = last_line ? '0 : l_q + 32'd1;
      d_d     = last_line ? d_q + 32'd1 : d_q;
      state_d = last_line && last_dest ? S_FIN : state_q;
    end
    if (state_q == S_FIN) begin
      state_d = done_q ? S_IDLE : S_FIN;
      done_d  = !done_q && (!out_valid || AXIS_M_TREADY);
    end
    data = state_q == S_INSTR ? DATAW'(cmd_q.instr) : SRC_TDATA;
    user = '0;
    user[user_op_lsb(RFAW) +: 2] = cmd_q.op;
    if (state_q == S_WEIGHTS) begin
      user[RFAW-1:0] = rfaddr_q;
      user[user_line_lsb(RFAW) +: LINES] = LINES'(1) << l_q;
    end
    bus = {data, user, DESTW'(cmd_q.dest + d_q), id_q, 1'b1};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      rfaddr_q <= '0;
      id_q     <= '0;
      d_q      <= '0;
      l_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rfaddr_q <= rfaddr_d;
      id_q     <= id_d;
      d_q      <= d_d;
      l_q      <= l_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  axis_out_reg #(.W(BW)) u_out (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (gen),
    .in_ready (can_acc),
    .in_data  (bus),
    .out_valid(out_valid),
    .out_ready(AXIS_M_TREADY),
    .out_data (out_bus)
  );
  assign {AXIS_M_TDATA, AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID, AXIS_M_TLAST} = out_bus;
  assign AXIS_M_TVALID = out_valid;
  assign CMD_READY     = state_q == S_IDLE && !RST;
  assign SRC_TREADY    = src_st && can_acc && !RST;
  assign DONE          = done_q;
  assign ERR           = err_q;
endmodule
